poly_shift: RTL and testbench

POLY_SHIFT -- requirements
Module: poly_shift

---
 rtl/poly_shift.sv | 113 +++++++++++
 tb/tb_poly_shift.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/poly_shift.sv
// poly_shift: falling-edge XNOR LFSR / shift register with parallel load, serial and injected-feedback modes.
// Define POLY_SHIFT_WRAP_EN to enable the wrap marker and step counter; otherwise both outputs read 0.
module poly_shift #(
  parameter int                WIDTH    = 9,
  parameter logic [WIDTH-1:0]  TAPS     = WIDTH'(9'h011),
  parameter logic [WIDTH-1:0]  WRAP_VAL = '0
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             enn,
  input  logic             ld,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       mode,
  input  logic             sin,
  output logic [WIDTH-1:0] Q,
  output logic             sOut,
  output logic             wrap,
  output logic [WIDTH-1:0] stepCnt
);

  typedef enum logic [1:0] {
    MODE_HOLD     = 2'b00,
    MODE_POLY     = 2'b01,
    MODE_SERIAL   = 2'b10,
    MODE_POLY_XOR = 2'b11
  } mode_e;

  if (WIDTH < 2 || WIDTH > 17 || $bits(WRAP_VAL) != WIDTH) begin : g_param_check
    $error("poly_shift: WIDTH must be in 2..17");
  end

  mode_e            mode_s;
  logic [WIDTH-1:0] q_q, q_d;
  logic             fb;
  logic             all_ones;

  assign mode_s   = mode_e'(mode);
  assign fb       = ~^(q_q & TAPS);
  assign all_ones = &q_q;

  // All-ones is the XNOR lockup state; poly modes force it to zero.
  always_comb begin
    q_d = q_q;
    if (enn) begin
      if (ld) begin
        q_d = D;
      end else begin
        case (mode_s)
          MODE_POLY:     q_d = all_ones ? '0 : {fb, q_q[WIDTH-1:1]};
          MODE_SERIAL:   q_d = {sin, q_q[WIDTH-1:1]};
          MODE_POLY_XOR: q_d = all_ones ? '0 : {fb ^ sin, q_q[WIDTH-1:1]};
          default:       q_d = q_q;
        endcase
      end
    end
  end

  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q    = q_q;
  assign sOut = q_q[0];

`ifdef POLY_SHIFT_WRAP_EN
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             poly_step;
  logic             clear_step;

  assign poly_step  = enn && !ld && (mode_s == MODE_POLY || mode_s == MODE_POLY_XOR);
  assign clear_step = enn && (ld || mode_s == MODE_SERIAL);

  // Hold mode and disabled edges keep both wrap and the counter.
  always_comb begin
    wrap_d = wrap_q;
    cnt_d  = cnt_q;
    if (clear_step) begin
      wrap_d = 1'b0;
      cnt_d  = '0;
    end else if (poly_step) begin
      if (q_d == WRAP_VAL) begin
        wrap_d = 1'b1;
        cnt_d  = '0;
      end else begin
        wrap_d = 1'b0;
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      wrap_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      wrap_q <= wrap_d;
      cnt_q  <= cnt_d;
    end
  end

  assign wrap    = wrap_q;
  assign stepCnt = cnt_q;
`else
  assign wrap    = 1'b0;
  assign stepCnt = '0;
`endif

endmodule

// File: tb/tb_poly_shift.sv
// Self-checking bench for poly_shift (WIDTH=4, TAPS=4'h3, WRAP_VAL=0); follows POLY_SHIFT_WRAP_EN.
module tb_poly_shift;

  localparam int         W  = 4;
  localparam logic [3:0] TP = 4'h3;
  localparam logic [3:0] WV = 4'h0;
`ifdef POLY_SHIFT_WRAP_EN
  localparam bit WRAP_ON = 1'b1;
`else
  localparam bit WRAP_ON = 1'b0;
`endif

  logic       clk  = 1'b0;
  logic       nRst = 1'b1;
  logic       enn  = 1'b0;
  logic       ld   = 1'b0;
  logic [3:0] D    = 4'h0;
  logic [1:0] mode = 2'b00;
  logic       sin  = 1'b0;
  logic [3:0] Q;
  logic       sOut;
  logic       wrap;
  logic [3:0] stepCnt;

  int checks = 0;
  int errors = 0;

  int mq   = 0;
  int mwrap = 0;
  int mcnt = 0;

  typedef struct {
    logic       enn;
    logic       ld;
    logic [3:0] d;
    logic [1:0] mode;
    logic       sin;
    logic [3:0] expQ;
  } vec_t;

  vec_t tbl [16];

  poly_shift #(.WIDTH(W), .TAPS(TP), .WRAP_VAL(WV)) dut (
    .clk(clk), .nRst(nRst), .enn(enn), .ld(ld), .D(D), .mode(mode), .sin(sin),
    .Q(Q), .sOut(sOut), .wrap(wrap), .stepCnt(stepCnt)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: next state from the mode rules using plain integer arithmetic.
  task automatic modelStep(input logic e, input logic l, input logic [3:0] d,
                           input logic [1:0] m, input logic s);
    int fbit;
    if (!e) return;
    if (l) begin
      mq = int'(d); mwrap = 0; mcnt = 0;
      return;
    end
    case (m)
      2'd0: ;
      2'd2: begin
        mq = (mq >> 1) | (int'(s) << (W - 1));
        mwrap = 0; mcnt = 0;
      end
      default: begin
        if (mq == (1 << W) - 1) begin
          mq = 0;
        end else begin
          fbit = ($countones(mq & int'(TP)) % 2 == 0) ? 1 : 0;
          if (m == 2'd3) fbit = fbit ^ int'(s);
          mq = (mq >> 1) | (fbit << (W - 1));
        end
        if (mq == int'(WV)) begin
          mwrap = 1; mcnt = 0;
        end else begin
          mwrap = 0; mcnt = (mcnt + 1) % (1 << W);
        end
      end
    endcase
  endtask

  task automatic applyStimulus(input logic e, input logic l, input logic [3:0] d,
                               input logic [1:0] m, input logic s);
    enn = e; ld = l; D = d; mode = m; sin = s;
    @(negedge clk);
    modelStep(e, l, d, m, s);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, " Q"}, 32'(Q), mq);
    checkVal({tag, " sOut"}, 32'(sOut), mq & 1);
    checkVal({tag, " wrap"}, 32'(wrap), WRAP_ON ? mwrap : 0);
    checkVal({tag, " stepCnt"}, 32'(stepCnt), WRAP_ON ? mcnt : 0);
  endtask

  task automatic doReset(input string tag);
    #2;
    nRst = 1'b0;
    enn = 1'b0; ld = 1'b0; D = 4'h0; mode = 2'b00; sin = 1'b0;
    #1;
    mq = 0; mwrap = 0; mcnt = 0;
    checkOutput(tag);
    @(negedge clk);
    #2;
    nRst = 1'b1;
  endtask

  initial begin
    logic [3:0] firstQ [3];
    logic [3:0] saveQ;
    logic       saveW;
    logic [3:0] saveC;

    firstQ[0] = 4'h8; firstQ[1] = 4'hC; firstQ[2] = 4'hE;

    tbl[0]  = '{1'b1, 1'b0, 4'h0, 2'b01, 1'b0, 4'h8};
    tbl[1]  = '{1'b1, 1'b0, 4'h0, 2'b01, 1'b0, 4'hC};
    tbl[2]  = '{1'b1, 1'b0, 4'h0, 2'b01, 1'b0, 4'hE};
    tbl[3]  = '{1'b1, 1'b1, 4'hF, 2'b01, 1'b0, 4'hF};
    tbl[4]  = '{1'b1, 1'b0, 4'h0, 2'b01, 1'b0, 4'h0};
    tbl[5]  = '{1'b1, 1'b0, 4'h0, 2'b10, 1'b1, 4'h8};
    tbl[6]  = '{1'b1, 1'b0, 4'h0, 2'b10, 1'b0, 4'h4};
    tbl[7]  = '{1'b1, 1'b0, 4'h0, 2'b10, 1'b1, 4'hA};
    tbl[8]  = '{1'b1, 1'b0, 4'h0, 2'b10, 1'b1, 4'hD};
    tbl[9]  = '{1'b1, 1'b0, 4'h0, 2'b00, 1'b1, 4'hD};
    tbl[10] = '{1'b0, 1'b1, 4'h3, 2'b10, 1'b0, 4'hD};
    tbl[11] = '{1'b1, 1'b0, 4'h0, 2'b11, 1'b1, 4'hE};
    tbl[12] = '{1'b1, 1'b0, 4'h0, 2'b11, 1'b0, 4'h7};
    tbl[13] = '{1'b1, 1'b0, 4'h0, 2'b11, 1'b0, 4'hB};
    tbl[14] = '{1'b1, 1'b1, 4'hF, 2'b11, 1'b0, 4'hF};
    tbl[15] = '{1'b1, 1'b0, 4'h0, 2'b11, 1'b1, 4'h0};

    $display("[TB] directed table");
    doReset("reset0");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(tbl[i].enn, tbl[i].ld, tbl[i].d, tbl[i].mode, tbl[i].sin);
      checkVal($sformatf("tbl%0d Q", i), 32'(Q), 32'(tbl[i].expQ));
      checkVal($sformatf("tbl%0d sOut", i), 32'(sOut), 32'(tbl[i].expQ[0]));
      checkOutput($sformatf("tbl%0d model", i));
    end

    $display("[TB] period sequence with enable hold");
    doReset("reset1");
    for (int s = 1; s <= 15; s++) begin
      applyStimulus(1'b1, 1'b0, 4'h0, 2'b01, 1'b0);
      checkOutput($sformatf("period%0d", s));
      if (s <= 3) checkVal($sformatf("first%0d Q", s), 32'(Q), 32'(firstQ[s-1]));
      if (s < 15) checkVal($sformatf("period%0d nonzero", s), 32'(Q != 4'h0), 1);
      if (s == 5) begin
        saveQ = Q; saveW = wrap; saveC = stepCnt;
        for (int h = 0; h < 5; h++) begin
          applyStimulus(1'b0, 1'(h), 4'($urandom), 2'(h), 1'(h + 1));
          checkVal($sformatf("hold%0d Q", h), 32'(Q), 32'(saveQ));
          checkVal($sformatf("hold%0d wrap", h), 32'(wrap), 32'(saveW));
          checkVal($sformatf("hold%0d stepCnt", h), 32'(stepCnt), 32'(saveC));
        end
      end
      if (s == 14) checkVal("cnt at 14", 32'(stepCnt), WRAP_ON ? 14 : 0);
      if (s == 15) begin
        checkVal("Q at 15", 32'(Q), 0);
        checkVal("wrap at 15", 32'(wrap), WRAP_ON ? 1 : 0);
        checkVal("cnt at 15", 32'(stepCnt), 0);
      end
    end
    applyStimulus(1'b1, 1'b0, 4'h0, 2'b01, 1'b0);
    checkVal("Q at 16", 32'(Q), 8);
    checkVal("wrap at 16", 32'(wrap), 0);
    checkVal("cnt at 16", 32'(stepCnt), WRAP_ON ? 1 : 0);

    $display("[TB] async reset mid-sequence");
    doReset("reset2");
    for (int s = 1; s <= 7; s++) begin
      applyStimulus(1'b1, 1'b0, 4'h0, 2'b01, 1'b0);
      checkOutput($sformatf("pre%0d", s));
    end
    checkVal("cnt before reset", 32'(stepCnt), WRAP_ON ? 7 : 0);
    #2;
    nRst = 1'b0;
    #1;
    checkVal("async Q", 32'(Q), 0);
    checkVal("async stepCnt", 32'(stepCnt), 0);
    checkVal("async wrap", 32'(wrap), 0);
    mq = 0; mwrap = 0; mcnt = 0;
    @(negedge clk);
    #1;
    checkVal("reset held Q", 32'(Q), 0);
    #1;
    nRst = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'h0, 2'b01, 1'b0);
    checkVal("post-reset Q", 32'(Q), 8);
    checkOutput("post-reset");

    $display("[TB] randomized stimulus");
    for (int r = 0; r < 400; r++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                    4'($urandom), 2'($urandom), 1'($urandom));
      checkOutput($sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
